hazard_unit_mc: RTL and testbench

Second-generation hazard unit for the 5-stage RV32I pipeline.
- Keeps EX-stage forwarding selection and branch flushing.
- Adds a sequential controller for multi-cycle load-use stalls (configurable load latency) and for multi-cycle MDU (mul/div) operations held in E.
- Sits beside the datapath and drives stall/flush enables of the IF/ID, ID/EX and EX/MEM pipeline registers.

---
 rtl/hazard_unit_mc_if.sv | 33 +++
 rtl/hazard_unit_mc.sv | 155 +++++++++++++++
 tb/tb_hazard_unit_mc.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_mc_if.sv
// Pipeline <-> hazard unit signal bundle for the 5-stage RV32I core.
// The datapath (master) drives register fields, write enables and the branch/MDU
// status. The hazard unit (slave) returns forwarding selects, stall/flush enables,
// busy and a debug copy of its controller state.
// Handshake semantics: none of these signals form a valid/ready pair. Every signal
// is level-sensitive and sampled within the same cycle. The hazard unit answers
// combinationally in that cycle, so a hazard seen in cycle N stalls cycle N.
interface hazard_unit_mc_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic              RegWriteM, RegWriteW, ResultSrcEb0, PCSrcE;
  logic              mdu_start_e, mdu_done;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, StallE;
  logic              FlushD, FlushE, FlushM;
  logic              busy;
  logic [1:0]        stateDbg;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcEb0, PCSrcE, mdu_start_e, mdu_done,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM, busy, stateDbg
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcEb0, PCSrcE, mdu_start_e, mdu_done,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
    output FlushD, FlushE, FlushM, busy, stateDbg
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage RV32I pipeline. It provides EX-stage forwarding
// selection and branch flushing. It also runs a small controller that holds the
// front end for multi-cycle load-use stalls (LOAD_LAT bubbles) and for
// multi-cycle MDU operations parked in E.
// Optional feature macro: HAZ_PERF_CNT_EN adds saturating stall/flush cycle
// counters with a synchronous clear (perf_clr).
module hazard_unit_mc #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  hazard_unit_mc_if.slave  hz
`ifdef HAZ_PERF_CNT_EN
  ,
  input  logic             perf_clr,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
`endif
);

  localparam logic [REG_AW-1:0] X0 = '0;

  if (LOAD_LAT < 1 || LOAD_LAT > 4 || CNT_W < 1) begin : gBadParam
    $error("hazard_unit_mc: LOAD_LAT must be 1..4 and CNT_W >= 1");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    MDU_BUSY  = 2'd2
  } state_t;

  state_t     state, stateNext;
  logic [2:0] loadCnt, loadCntNext;
  logic       loadUse;
  logic       stallF, stallD, stallE, flushD, flushE, flushM;

  // Forwarding select: the M-stage result is newer than the W-stage result, so M wins. x0 never forwards.
  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    if (reset_n) begin
      if (hz.Rs1E != X0 && hz.Rs1E == hz.RdM && hz.RegWriteM)      hz.ForwardAE = 2'b10;
      else if (hz.Rs1E != X0 && hz.Rs1E == hz.RdW && hz.RegWriteW) hz.ForwardAE = 2'b01;
      if (hz.Rs2E != X0 && hz.Rs2E == hz.RdM && hz.RegWriteM)      hz.ForwardBE = 2'b10;
      else if (hz.Rs2E != X0 && hz.Rs2E == hz.RdW && hz.RegWriteW) hz.ForwardBE = 2'b01;
    end
  end

  assign loadUse = hz.ResultSrcEb0 && hz.RdE != X0 &&
                   (hz.Rs1D == hz.RdE || hz.Rs2D == hz.RdE);

  // Controller state register and load-bubble counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      loadCnt <= '0;
    end else begin
      state   <= stateNext;
      loadCnt <= loadCntNext;
    end
  end

  // Next state and stall/flush enables. The first bubble of any hazard is raised in IDLE itself.
  always_comb begin
    stateNext   = state;
    loadCntNext = loadCnt;
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    case (state)
      IDLE: begin
        if (hz.PCSrcE) begin
          flushD = 1'b1;
          flushE = 1'b1;
        end else if (loadUse) begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
          if (LOAD_LAT > 1) begin
            stateNext   = LOAD_WAIT;
            loadCntNext = 3'(LOAD_LAT - 1);
          end
        end else if (hz.mdu_start_e && !hz.mdu_done) begin
          stallF = 1'b1;
          stallD = 1'b1;
          stallE = 1'b1;
          flushM = 1'b1;
          stateNext = MDU_BUSY;
        end
      end
      LOAD_WAIT: begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
        if (loadCnt <= 3'd1) begin
          stateNext   = IDLE;
          loadCntNext = '0;
        end else begin
          loadCntNext = loadCnt - 3'd1;
        end
      end
      MDU_BUSY: begin
        // E holds the MDU op, so a branch resolved there cannot be real yet.
        if (hz.mdu_done) begin
          stateNext = IDLE;
        end else begin
          stallF = 1'b1;
          stallD = 1'b1;
          stallE = 1'b1;
          flushM = 1'b1;
        end
      end
      default: begin
        stateNext   = IDLE;
        loadCntNext = '0;
      end
    endcase
  end

  // Outputs are held low while reset is asserted, independent of the clock.
  always_comb begin
    hz.StallF   = reset_n & stallF;
    hz.StallD   = reset_n & stallD;
    hz.StallE   = reset_n & stallE;
    hz.FlushD   = reset_n & flushD;
    hz.FlushE   = reset_n & flushE;
    hz.FlushM   = reset_n & flushM;
    hz.busy     = reset_n & (state == LOAD_WAIT || state == MDU_BUSY);
    hz.stateDbg = state;
  end

`ifdef HAZ_PERF_CNT_EN
  // Saturating performance counters. A clear takes precedence over an increment in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (hz.StallF && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
      if ((hz.FlushD || hz.FlushE || hz.FlushM) && !(&flush_cycles))
        flush_cycles <= flush_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed and randomized bench for hazard_unit_mc (LOAD_LAT=3, CNT_W=4).
// The reference model tracks the remaining load bubbles and whether an MDU op is
// outstanding. From these and the current inputs it derives the expected outputs
// each cycle.
module tb_hazard_unit_mc;
  localparam int LL    = 3;
  localparam int CW    = 4;
  localparam int SATV  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  hazard_unit_mc_if #(.REG_AW(5)) hz ();

`ifdef HAZ_PERF_CNT_EN
  logic          perf_clr = 1'b0;
  logic [CW-1:0] stall_cycles, flush_cycles;
  hazard_unit_mc #(.REG_AW(5), .LOAD_LAT(LL), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(rst_n), .hz(hz),
    .perf_clr(perf_clr), .stall_cycles(stall_cycles), .flush_cycles(flush_cycles));
`else
  hazard_unit_mc #(.REG_AW(5), .LOAD_LAT(LL), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(rst_n), .hz(hz));
`endif

  // Clock generation.
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model state.
  int loadLeft = 0;
  bit mduActive = 1'b0;
  int nLoad;
  bit nMdu;
  int stallCnt = 0, flushCnt = 0;
  bit pStall, pFlush;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int fwd(input logic [4:0] rs);
    if (rs != 0 && rs == hz.RdM && hz.RegWriteM) return 2;
    if (rs != 0 && rs == hz.RdW && hz.RegWriteW) return 1;
    return 0;
  endfunction

  task automatic setIdle();
    hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0;
    hz.RdE = 0; hz.RdM = 0; hz.RdW = 0;
    hz.RegWriteM = 0; hz.RegWriteW = 0; hz.ResultSrcEb0 = 0; hz.PCSrcE = 0;
    hz.mdu_start_e = 0; hz.mdu_done = 0;
  endtask

  // Compute expected outputs for the present inputs and compare against the DUT.
  task automatic checkNow(input string tag);
    bit eSF = 0, eSD = 0, eSE = 0, eFD = 0, eFE = 0, eFM = 0, eBusy = 0, lu;
    int eFA = 0, eFB = 0;
    nLoad = loadLeft;
    nMdu = mduActive;
    if (rst_n) begin
      eFA = fwd(hz.Rs1E);
      eFB = fwd(hz.Rs2E);
      lu = hz.ResultSrcEb0 && hz.RdE != 0 && (hz.Rs1D == hz.RdE || hz.Rs2D == hz.RdE);
      if (loadLeft > 0) begin
        eSF = 1; eSD = 1; eFE = 1; eBusy = 1;
        nLoad = loadLeft - 1;
      end else if (mduActive) begin
        eBusy = 1;
        if (!hz.mdu_done) begin eSF = 1; eSD = 1; eSE = 1; eFM = 1; end
        else nMdu = 0;
      end else if (hz.PCSrcE) begin
        eFD = 1; eFE = 1;
      end else if (lu) begin
        eSF = 1; eSD = 1; eFE = 1;
        nLoad = LL - 1;
      end else if (hz.mdu_start_e && !hz.mdu_done) begin
        eSF = 1; eSD = 1; eSE = 1; eFM = 1;
        nMdu = 1;
      end
    end
    pStall = eSF;
    pFlush = eFD | eFE | eFM;
    chk({tag, ".fwdA"}, 16'(hz.ForwardAE), 16'(eFA));
    chk({tag, ".fwdB"}, 16'(hz.ForwardBE), 16'(eFB));
    chk({tag, ".stall"}, 16'({hz.StallF, hz.StallD, hz.StallE}), 16'({eSF, eSD, eSE}));
    chk({tag, ".flush"}, 16'({hz.FlushD, hz.FlushE, hz.FlushM}), 16'({eFD, eFE, eFM}));
    chk({tag, ".busy"}, 16'(hz.busy), 16'(eBusy));
`ifdef HAZ_PERF_CNT_EN
    chk({tag, ".stallCyc"}, 16'(stall_cycles), 16'(stallCnt));
    chk({tag, ".flushCyc"}, 16'(flush_cycles), 16'(flushCnt));
`endif
  endtask

  // Advance the model across one rising edge.
  task automatic commit();
    if (!rst_n) begin
      loadLeft = 0; mduActive = 0; stallCnt = 0; flushCnt = 0;
    end else begin
      loadLeft = nLoad;
      mduActive = nMdu;
`ifdef HAZ_PERF_CNT_EN
      if (perf_clr) begin
        stallCnt = 0; flushCnt = 0;
      end else begin
        if (pStall && stallCnt < SATV) stallCnt++;
        if (pFlush && flushCnt < SATV) flushCnt++;
      end
`endif
    end
  endtask

  // One cycle: inputs were set at the falling edge; check, cross the rising edge, return at the next falling edge.
  task automatic cycle(input string tag);
    #1 checkNow(tag);
    @(posedge clk);
    commit();
    @(negedge clk);
  endtask

  initial begin
    setIdle();
    rst_n = 0;
    @(negedge clk);
    hz.Rs1E = 5; hz.RdM = 5; hz.RegWriteM = 1;
    hz.ResultSrcEb0 = 1; hz.RdE = 4; hz.Rs1D = 4;
    cycle("reset");
    rst_n = 1;
    setIdle();

    // Forwarding.
    hz.Rs1E = 5; hz.RdM = 5; hz.RegWriteM = 1; hz.RdW = 5; hz.RegWriteW = 1;
    cycle("fwdM");
    setIdle();
    hz.Rs2E = 0; hz.RdM = 0; hz.RegWriteM = 1;
    cycle("fwdX0");
    setIdle();
    hz.Rs2E = 7; hz.RdW = 7; hz.RegWriteW = 1;
    cycle("fwdW");
    setIdle();

    // Load-use for one cycle: expect LL bubbles.
    hz.ResultSrcEb0 = 1; hz.RdE = 4; hz.Rs1D = 4;
    cycle("lu0");
    setIdle();
    for (int i = 0; i < 4; i++) cycle("luTail");
    hz.ResultSrcEb0 = 1; hz.RdE = 0; hz.Rs1D = 0;
    cycle("luX0");
    setIdle();

    // MDU: start at cycle 0, done at cycle 5.
    hz.mdu_start_e = 1;
    for (int i = 0; i < 5; i++) cycle("mdu");
    hz.mdu_start_e = 0; hz.mdu_done = 1;
    cycle("mduDone");
    hz.mdu_done = 0;
    cycle("mduAfter");
    hz.mdu_start_e = 1; hz.mdu_done = 1;
    cycle("mduSingle");
    setIdle();

    // Branch beats load-use in IDLE.
    hz.PCSrcE = 1; hz.ResultSrcEb0 = 1; hz.RdE = 6; hz.Rs2D = 6;
    cycle("brLu");
    setIdle();
    cycle("brAfter");

    // Branch during MDU is ignored.
    hz.mdu_start_e = 1;
    cycle("mduBr0");
    hz.PCSrcE = 1;
    cycle("mduBr1");
    hz.PCSrcE = 0; hz.mdu_done = 1;
    cycle("mduBrDone");
    setIdle();

    // Reset in the second MDU_BUSY cycle.
    hz.mdu_start_e = 1;
    cycle("rstMdu0");
    cycle("rstMdu1");
    #2 rst_n = 0;
    cycle("rstAsync");
    rst_n = 1;
    hz.mdu_start_e = 0;
    for (int i = 0; i < 3; i++) cycle("rstRel");

`ifdef HAZ_PERF_CNT_EN
    // Counter saturation and clear.
    hz.ResultSrcEb0 = 1; hz.RdE = 9; hz.Rs1D = 9;
    for (int i = 0; i < 20; i++) cycle("perfSat");
    chk("perfSatVal", 16'(stall_cycles), 16'(SATV));
    setIdle();
    perf_clr = 1;
    cycle("perfClr");
    perf_clr = 0;
    cycle("perfClrd");
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      hz.Rs1D = 5'($urandom_range(0, 3)); hz.Rs2D = 5'($urandom_range(0, 3));
      hz.Rs1E = 5'($urandom_range(0, 3)); hz.Rs2E = 5'($urandom_range(0, 3));
      hz.RdE = 5'($urandom_range(0, 3)); hz.RdM = 5'($urandom_range(0, 3));
      hz.RdW = 5'($urandom_range(0, 3));
      hz.RegWriteM = 1'($urandom_range(0, 1)); hz.RegWriteW = 1'($urandom_range(0, 1));
      hz.ResultSrcEb0 = ($urandom_range(0, 9) < 3);
      hz.PCSrcE = ($urandom_range(0, 9) < 2);
      hz.mdu_start_e = ($urandom_range(0, 9) < 2);
      hz.mdu_done = ($urandom_range(0, 9) < 3);
`ifdef HAZ_PERF_CNT_EN
      perf_clr = ($urandom_range(0, 19) == 0);
`endif
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
